// File: rtl/trng_com_rx.sv
`default_nettype none
// ----------------------------------------------------------------------
// trng_com_rx: 8N1 UART receiver feeding a byte FIFO with CTS flow control
// Rev 1.0
// ----------------------------------------------------------------------
module trng_com_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_serial_data,
  input  logic       i_read,
  output logic [7:0] o_dat,
  output logic       o_valid,
  output logic       o_serial_cts_n,
  output logic       o_new_frame,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_CYC_ONE = CW'(1);
  localparam logic [AW:0]   C_FULL    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   C_CTS_LVL = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   C_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]    sync_q;
  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          frame_err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          cts_n_q, new_frame_q, overrun_q;

  logic w_line, w_push, w_pop, w_full, w_push_ok, w_drop;

  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], i_serial_data};
  end
  assign w_line = sync_q[1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cyc_q <= '0;
          if (!w_line) state_q <= START;
        end
        START: begin
          if (cyc_q == C_HALF_M1) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            state_q <= w_line ? IDLE : DATA;
          end else begin
            cyc_q <= cyc_q + C_CYC_ONE;
          end
        end
        DATA: begin
          if (cyc_q == C_BIT_M1) begin
            cyc_q   <= '0;
            shreg_q <= {w_line, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cyc_q <= cyc_q + C_CYC_ONE;
          end
        end
        STOP: begin
          // Back to IDLE at mid-stop so a following start edge is not missed
          if (cyc_q == C_BIT_M1) begin
            cyc_q       <= '0;
            state_q     <= IDLE;
            frame_err_q <= ~w_line;
          end else begin
            cyc_q <= cyc_q + C_CYC_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_push    = (state_q == STOP) && (cyc_q == C_BIT_M1) && w_line;
  assign w_pop     = i_read && (count_q != '0);
  assign w_full    = (count_q == C_FULL);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_comb begin
    count_d = count_q;
    if (w_push_ok && !w_pop)      count_d = count_q + C_CNT_ONE;
    else if (!w_push_ok && w_pop) count_d = count_q - C_CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      cts_n_q     <= 1'b1;
      new_frame_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (w_push_ok) wptr_q <= wptr_q + C_PTR_ONE;
      if (w_pop)     rptr_q <= rptr_q + C_PTR_ONE;
      count_q     <= count_d;
      cts_n_q     <= (count_d >= C_CTS_LVL);
      new_frame_q <= w_push_ok;
      overrun_q   <= w_drop;
    end
  end

  // When full, push-with-pop writes the slot being vacated by the head
  always_ff @(posedge i_clk) begin
    if (w_push_ok) mem_q[wptr_q] <= shreg_q;
  end

  assign o_valid        = (count_q != '0);
  assign o_dat          = o_valid ? mem_q[rptr_q] : 8'h00;
  assign o_serial_cts_n = cts_n_q;
  assign o_new_frame    = new_frame_q;
  assign o_frame_err    = frame_err_q;
  assign o_overrun      = overrun_q;

endmodule
`default_nettype wire
